// File: rtl/crc_checker_pkg.sv
// crc_checker_pkg: shared CRC widths, generator polynomial and one-hot checker states.
package crc_checker_pkg;

    localparam int CRC_DATA_WIDTH   = 32;
    localparam int CRC_HASH_LENGTH  = 64;
    localparam int CRC_PARITY_COUNT = CRC_HASH_LENGTH / CRC_DATA_WIDTH;
    localparam logic [63:0] CRC_POLY = 64'h42F0_E1EB_A9EA_3693;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        MSG  = 4'b0010,
        PAR  = 4'b0100,
        DONE = 4'b1000
    } state_t;

endpackage

// File: rtl/CRC_parallel_m_lfs_XOR.sv
// CRC_parallel_m_lfs_XOR: one-word parallel LFSR update shared by the CRC generator and checker.
module CRC_parallel_m_lfs_XOR
    import crc_checker_pkg::*;
#(
    parameter int DATA_WIDTH  = CRC_DATA_WIDTH,
    parameter int HASH_LENGTH = CRC_HASH_LENGTH,
    parameter logic [HASH_LENGTH-1:0] POLY = CRC_POLY[HASH_LENGTH-1:0]
) (
    input  logic [DATA_WIDTH-1:0]  r_message,
    input  logic [HASH_LENGTH-1:0] r_parity,
    output logic [HASH_LENGTH-1:0] w_next_parity
);

    // Unrolled MSB-first serial LFSR; synthesis flattens it into the XOR matrix.
    always_comb begin
        w_next_parity = r_parity;
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            w_next_parity = {w_next_parity[HASH_LENGTH-2:0], 1'b0}
                          ^ (POLY & {HASH_LENGTH{w_next_parity[HASH_LENGTH-1] ^ r_message[i]}});
    end

endmodule

// File: rtl/crc_checker.sv
// crc_checker: recomputes page CRC over message words and compares it with received parity words.
module crc_checker
    import crc_checker_pkg::*;
#(
    parameter int DATA_WIDTH       = CRC_DATA_WIDTH,
    parameter int HASH_LENGTH      = CRC_HASH_LENGTH,
    parameter int INPUT_COUNT_BITS = 13,
    parameter int INPUT_COUNT      = 4158,
    parameter int PARITY_COUNT     = HASH_LENGTH / DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_nRESET,
    input  logic                  i_execute_crc_chk,
    input  logic                  i_abort,
    input  logic                  i_message_valid,
    input  logic [DATA_WIDTH-1:0] i_message,
    output logic                  o_crc_chk_start,
    output logic                  o_last_message,
    output logic                  o_crc_chk_complete,
    output logic                  o_crc_error,
    output logic                  o_crc_available
);

    localparam logic [INPUT_COUNT_BITS-1:0] MSG_LAST  = INPUT_COUNT_BITS'(INPUT_COUNT - 1);
    localparam logic [INPUT_COUNT_BITS-1:0] PAR_FIRST = INPUT_COUNT_BITS'(INPUT_COUNT);
    localparam logic [INPUT_COUNT_BITS-1:0] PAR_LAST  = INPUT_COUNT_BITS'(INPUT_COUNT + PARITY_COUNT - 1);

    state_t                      r_state, w_next_state;
    logic [INPUT_COUNT_BITS-1:0] r_count;
    logic [DATA_WIDTH-1:0]       r_message;
    logic [HASH_LENGTH-1:0]      r_parity, w_next_parity, w_par;
    logic                        r_mismatch, r_error, r_start, w_accept;

    CRC_parallel_m_lfs_XOR #(
        .DATA_WIDTH (DATA_WIDTH),
        .HASH_LENGTH(HASH_LENGTH)
    ) u_lfsr (
        .r_message    (r_message),
        .r_parity     (r_parity),
        .w_next_parity(w_next_parity)
    );

    assign w_accept           = i_execute_crc_chk & i_message_valid;
    // The last message word is still pending in r_message when the first parity word arrives.
    assign w_par              = (r_count == PAR_FIRST) ? w_next_parity : r_parity;
    assign o_last_message     = (r_state == PAR) & i_message_valid & (r_count == PAR_LAST);
    assign o_crc_chk_complete = (r_state == DONE) & ~i_abort;
    assign o_crc_error        = o_crc_chk_complete ? r_mismatch : r_error;
    assign o_crc_available    = (r_state == IDLE);
    assign o_crc_chk_start    = r_start;

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    w_next_state = w_accept ? ((INPUT_COUNT == 1) ? PAR : MSG) : IDLE;
            MSG:     w_next_state = (i_message_valid & (r_count == MSG_LAST)) ? PAR : MSG;
            PAR:     w_next_state = o_last_message ? DONE : PAR;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (i_abort)
            w_next_state = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_nRESET)
        if (!i_nRESET)
            r_state <= IDLE;
        else
            r_state <= w_next_state;

    always_ff @(posedge i_clk or negedge i_nRESET) begin
        if (!i_nRESET) begin
            r_count    <= '0;
            r_message  <= '0;
            r_parity   <= '0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
            r_start    <= 1'b0;
        end else if (i_abort) begin
            r_count    <= '0;
            r_message  <= '0;
            r_parity   <= '0;
            r_mismatch <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_start <= (r_state == IDLE) & w_accept;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_message  <= i_message;
                    r_parity   <= '0;
                    r_count    <= INPUT_COUNT_BITS'(1);
                    r_mismatch <= 1'b0;
                    r_error    <= 1'b0;
                end
                MSG: if (i_message_valid) begin
                    r_parity  <= w_next_parity;
                    r_message <= i_message;
                    r_count   <= r_count + INPUT_COUNT_BITS'(1);
                end
                PAR: if (i_message_valid) begin
                    r_mismatch <= r_mismatch | (i_message != w_par[HASH_LENGTH-1 -: DATA_WIDTH]);
                    r_parity   <= w_par << DATA_WIDTH;
                    r_count    <= r_count + INPUT_COUNT_BITS'(1);
                end
                DONE: r_error <= r_mismatch;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: scoreboard bench for crc_checker, short codewords plus one default-size codeword.
module tb_crc_checker;

    localparam int N = 4;
    localparam int BIG_N = 4158;
    localparam logic [63:0] GEN_POLY = 64'h42F0E1EBA9EA3693;

    logic        clk = 1'b0, nrst = 1'b0;
    logic        exec, abort, valid, exec_b, valid_b;
    logic [31:0] msg, msg_b;
    logic        start, last, done, err, avail;
    logic        start_b, last_b, done_b, err_b, avail_b;
    int          vectors = 0, errors = 0, cyc = 0, done_cyc = 0;
    bit          exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    crc_checker #(.INPUT_COUNT(N)) dut (
        .i_clk(clk), .i_nRESET(nrst), .i_execute_crc_chk(exec), .i_abort(abort),
        .i_message_valid(valid), .i_message(msg), .o_crc_chk_start(start),
        .o_last_message(last), .o_crc_chk_complete(done), .o_crc_error(err),
        .o_crc_available(avail)
    );

    crc_checker dut_b (
        .i_clk(clk), .i_nRESET(nrst), .i_execute_crc_chk(exec_b), .i_abort(1'b0),
        .i_message_valid(valid_b), .i_message(msg_b), .o_crc_chk_start(start_b),
        .o_last_message(last_b), .o_crc_chk_complete(done_b), .o_crc_error(err_b),
        .o_crc_available(avail_b)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference CRC as the remainder of message * x^64 by long division.
    function automatic logic [63:0] crc_model(input logic [31:0] w[$]);
        logic [63:0] r;
        bit          b, top;
        r = '0;
        for (int i = 0; i < w.size() * 32 + 64; i++) begin
            b   = (i < w.size() * 32) ? w[i / 32][31 - (i % 32)] : 1'b0;
            top = r[63];
            r   = {r[62:0], b};
            if (top) r ^= GEN_POLY;
        end
        return r;
    endfunction

    task automatic build(input logic [31:0] a, b, c, d, output logic [31:0] cw[6]);
        logic [31:0] q[$];
        logic [63:0] p;
        q  = {a, b, c, d};
        p  = crc_model(q);
        cw = '{a, b, c, d, p[63:32], p[31:0]};
    endtask

    task automatic beat(input logic ex, input logic [31:0] d, input int idx, input bit chk_last);
        exec = ex; valid = 1'b1; msg = d;
        #1;
        if (chk_last) check($sformatf("last_msg[%0d]", idx), 64'(last), 64'(idx == N + 1));
        @(posedge clk); #1;
        exec = 1'b0; valid = 1'b0;
    endtask

    task automatic wait_avail();
        int n = 0;
        while (!avail && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("avail_wait", 64'(avail), 64'd1);
    endtask

    task automatic send_cw(input logic [31:0] cw[6], input int gap, input bit exp_err, input bit b2b);
        exp_q.push_back(exp_err);
        exec = 1'b1; valid = 1'b1; msg = cw[0];
        wait_avail();
        beat(1'b1, cw[0], 0, 1'b1);
        check("start_pulse", 64'(start), 64'd1);
        check("err_cleared", 64'(err), 64'd0);
        if (b2b) check("b2b_gap", 64'(cyc - done_cyc), 64'd2);
        for (int i = 1; i < 6; i++) begin
            repeat ($urandom_range(gap)) begin
                @(posedge clk); #1;
            end
            beat(1'b0, cw[i], i, 1'b1);
        end
        check("complete_latency", 64'(done), 64'd1);
        done_cyc = cyc;
        @(posedge clk); #1;
        check("complete_one_shot", 64'(done), 64'd0);
        check("err_held", 64'(err), 64'(exp_err));
    endtask

    always @(negedge clk)
        if (nrst && done) begin
            if (exp_q.size() == 0) check("unexpected_complete", 64'(done), 64'd0);
            else check("crc_error", 64'(err), 64'(exp_q.pop_front()));
        end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] zero[6], good[6], bad[6], bad2[6];
        logic [31:0] q[$];
        logic [63:0] p;
        int          nhigh, idx;
        exec = 0; abort = 0; valid = 0; msg = 0; exec_b = 0; valid_b = 0; msg_b = 0;
        #12;
        check("rst_avail", 64'(avail), 64'd1);
        check("rst_start", 64'(start), 64'd0);
        check("rst_complete", 64'(done), 64'd0);
        check("rst_error", 64'(err), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        #5 nrst = 1'b1;
        @(posedge clk); #1;

        build(32'h0, 32'h0, 32'h0, 32'h0, zero);
        build(32'h1, 32'h2, 32'h3, 32'h4, good);
        bad = good;
        bad[5] ^= 32'h1;
        bad2 = good;
        bad2[2] ^= 32'h8000_0000;
        send_cw(zero, 0, 1'b0, 1'b0);
        send_cw(good, 0, 1'b0, 1'b0);
        send_cw(bad, 0, 1'b1, 1'b0);
        send_cw(bad2, 0, 1'b1, 1'b0);
        send_cw(good, 5, 1'b0, 1'b0);
        send_cw(bad, 5, 1'b1, 1'b0);
        send_cw(bad2, 5, 1'b1, 1'b0);
        send_cw(good, 0, 1'b0, 1'b0);
        send_cw(bad, 0, 1'b1, 1'b1);
        send_cw(good, 0, 1'b0, 1'b1);

        // Abort while collecting message words.
        exec = 1'b1; valid = 1'b1; msg = good[0];
        wait_avail();
        beat(1'b1, good[0], 0, 1'b0);
        beat(1'b0, good[1], 1, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_avail", 64'(avail), 64'd1);
        check("abort_complete", 64'(done), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        send_cw(good, 2, 1'b0, 1'b0);

        // Asynchronous reset while receiving parity.
        exec = 1'b1; valid = 1'b1; msg = bad[0];
        wait_avail();
        for (int i = 0; i < 5; i++) beat(i == 0, bad[i], i, 1'b0);
        nrst = 1'b0;
        #2;
        check("nrst_avail", 64'(avail), 64'd1);
        check("nrst_complete", 64'(done), 64'd0);
        check("nrst_start", 64'(start), 64'd0);
        check("nrst_error", 64'(err), 64'd0);
        #5 nrst = 1'b1;
        @(posedge clk); #1;
        send_cw(good, 1, 1'b0, 1'b0);

        // Full-size codeword on the default-parameter instance.
        for (int i = 0; i < BIG_N; i++) q.push_back(32'hFFFF_FFFF);
        p = crc_model(q);
        nhigh = 0; idx = -1;
        for (int i = 0; i < BIG_N + 2; i++) begin
            exec_b = (i == 0); valid_b = 1'b1;
            msg_b = (i < BIG_N) ? 32'hFFFF_FFFF : ((i == BIG_N) ? p[63:32] : p[31:0]);
            #1;
            if (last_b) begin
                nhigh++;
                idx = i;
            end
            @(posedge clk); #1;
            if (i == 0) check("big_start", 64'(start_b), 64'd1);
        end
        exec_b = 1'b0; valid_b = 1'b0;
        check("big_complete", 64'(done_b), 64'd1);
        check("big_error", 64'(err_b), 64'd0);
        check("big_last_count", 64'(nhigh), 64'd1);
        check("big_last_index", 64'(idx), 64'(BIG_N + 1));
        @(posedge clk); #1;
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Read-path counterpart of the page CRC generator. It consumes one codeword per activation: INPUT_COUNT message words followed by PARITY_COUNT parity words, sent most-significant parity word first, exactly as the generator emits them.
- It recomputes the HASH_LENGTH-bit parity with the shared parallel-LFSR update matrix, compares it word-by-word against the received parity, and reports pass/fail.
- It sits after the NAND read data path and ahead of the DMA/buffer write.

Parameters:
- DATA_WIDTH, 32, bus word width.
- HASH_LENGTH, 64, CRC parity width.
- INPUT_COUNT_BITS, 13, counter width; INPUT_COUNT+PARITY_COUNT must be < 2^INPUT_COUNT_BITS.
- INPUT_COUNT, 4158, message words per codeword.
- PARITY_COUNT, 2, parity words per codeword; equals HASH_LENGTH/DATA_WIDTH.

Ports:
- i_clk, in, 1, clock.
- i_nRESET, in, 1, reset: asynchronous, active-low.
- i_execute_crc_chk, in, 1, starts a check when high together with i_message_valid while idle.
- i_abort, in, 1, synchronous abort; returns to idle with no completion pulse.
- i_message_valid, in, 1, word on i_message is valid; every valid beat is accepted (no backpressure) outside IDLE/DONE.
- i_message, in, DATA_WIDTH, message or parity word.
- o_crc_chk_start, out, 1, one-cycle pulse the cycle after word 0 is accepted.
- o_last_message, out, 1, combinational: i_message_valid & (count == INPUT_COUNT+PARITY_COUNT-1) in PAR.
- o_crc_chk_complete, out, 1, one-cycle pulse; result valid.
- o_crc_error, out, 1, 1 = any parity mismatch; held from complete until the next accepted start.
- o_crc_available, out, 1, high only in IDLE.

Behaviour:
- Reset values: state IDLE; r_count 0, r_message 0, r_parity 0, r_mismatch 0.
- Reset outputs: o_crc_available 1; o_crc_chk_start, o_crc_chk_complete and o_crc_error all 0.
- States are IDLE, MSG, PAR and DONE, one-hot encoded.
- IDLE:
  - On i_execute_crc_chk & i_message_valid: r_message <= i_message, r_parity <= 0, r_count <= 1, r_mismatch <= 0, o_crc_error cleared, go to MSG.
  - Valid without execute is ignored.
- MSG:
  - Valid beat with r_count < INPUT_COUNT: r_parity <= f(r_message, r_parity), r_message <= i_message, r_count++.
  - No valid beat: hold all registers (pause of any length).
  - Once r_count == INPUT_COUNT, move to PAR without consuming a cycle. Next-state is decided on r_count; the last message word stays pending in r_message.
- PAR, first parity beat (r_count == INPUT_COUNT):
  - w = f(r_message, r_parity), which folds in the last message word.
  - Mismatch |= (i_message != w[HASH_LENGTH-1 -: DATA_WIDTH]).
  - r_parity <= w << DATA_WIDTH; r_count++.
- PAR, later parity beats: mismatch |= (i_message != r_parity top word); r_parity <<= DATA_WIDTH; r_count++.
- PAR exit: after beat INPUT_COUNT+PARITY_COUNT-1, go to DONE. Pauses in PAR hold all registers.
- DONE (one cycle):
  - o_crc_chk_complete = 1; o_crc_error = r_mismatch, including a mismatch on the final beat.
  - Valid beats are ignored; next state is IDLE.
- Latency: complete asserts the cycle after the last parity word is accepted. Back-to-back codewords incur one DONE cycle plus one IDLE cycle.
- o_crc_error holds until the next start is accepted.
- i_abort has priority over all transitions: go to IDLE, clear counters and parity, no complete pulse, o_crc_error unchanged.
- Async reset mid-codeword: immediately IDLE with reset values; the partial codeword is discarded.
- Arithmetic: GF(2) only. f() is the shared combinational matrix with parity initialised to 0, bit-identical to the generator.
- Counter never wraps: the upper bound is enforced by the parameter rule above.

Decomposition:
- Shared CRC package holds:
  - the state one-hot localparams (IDLE/MSG/PAR/DONE);
  - DATA_WIDTH/HASH_LENGTH defaults;
  - a PARITY_COUNT = HASH_LENGTH/DATA_WIDTH constant.
- Sub-module: reuse the existing CRC_parallel_m_lfs_XOR (inputs r_message and r_parity; output w_next_parity) unchanged, so checker and generator share one matrix.

Test Plan:
- INPUT_COUNT=4; words 0,0,0,0 then parity 0,0 -> complete one cycle after the last parity beat, o_crc_error=0, start pulse one cycle after word 0.
- INPUT_COUNT=4; message 0x1,0x2,0x3,0x4 fed through the generator; checker receives message plus generator parity -> o_crc_error=0. Flip bit 0 of parity word 1 -> o_crc_error=1.
- Same codeword with message word 2 XOR 0x80000000 -> o_crc_error=1. Random i_message_valid gaps of 0–5 cycles in MSG and PAR -> identical results.
- Two codewords back-to-back (good, then bad) -> complete pulses 2 cycles apart from the prior complete to the next start; errors 0 then 1; o_crc_error cleared on the second start.
- Default params (4158+2 words, all 0xFFFFFFFF message with generator parity) -> error 0. o_last_message high exactly on beat 4159.
- Assert i_abort in MSG, and separately i_nRESET low in PAR -> IDLE next cycle (reset: immediately), no complete pulse, o_crc_available=1. A following good codeword passes.
